mips_fetch: RTL

//  Instruction fetch stage feeding the decoder/execute core. Owns the PC, issues word

---
 rtl/mips_fetch_if.sv | 25 ++
 rtl/mips_fetch.sv | 105 ++++++++++
 2 files changed

// File: rtl/mips_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoded-instruction stream and redirect.
// The fetch stage connects through master; memory and core connect through slave.
interface mips_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_busy;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_busy, mem_rvalid, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_busy, mem_rvalid, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/mips_fetch.sv
// MIPS instruction fetch: PC owner, credit-limited memory requests, in-order prefetch FIFO,
// and redirect flush that discards responses still in flight.
module mips_fetch #(
  parameter logic [31:0] PC_INIT    = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  mips_fetch_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  // Headroom: stale responses can accumulate across back-to-back redirects.
  localparam int unsigned CntW = PtrW + 4;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d, tail_pc_q, tail_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] occ_q, occ_d, out_q, out_d, drop_q, drop_d, credit;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic            head_valid, accept, push, pop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  always_comb begin
    head_valid      = (occ_q != '0);
    credit          = occ_q + (out_q - drop_q);
    bus.mem_req     = !reset && !bus.redirect_valid && (credit < Depth);
    bus.mem_addr    = fetch_pc_q;
    bus.instr_valid = head_valid;
    bus.instr       = head_valid ? fifo_instr_q[rd_ptr_q] : hold_instr_q;
    bus.instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : hold_pc_q;
  end

  always_comb begin
    accept       = bus.mem_req && !bus.mem_busy;
    push         = bus.mem_rvalid && (drop_q == '0) && !bus.redirect_valid;
    pop          = head_valid && bus.instr_ready && !bus.redirect_valid;
    fetch_pc_d   = fetch_pc_q;
    tail_pc_d    = tail_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    drop_d       = drop_q;
    hold_instr_d = bus.instr;
    hold_pc_d    = bus.instr_pc;
    out_d        = out_q + CntW'(accept) - CntW'(bus.mem_rvalid);
    if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      tail_pc_d  = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      drop_d     = out_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (bus.mem_rvalid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
        tail_pc_d = tail_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      occ_d = occ_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= PC_INIT;
      tail_pc_q    <= PC_INIT;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      out_q        <= '0;
      drop_q       <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      tail_pc_q    <= tail_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.mem_rdata;
      fifo_pc_q[wr_ptr_q]    <= tail_pc_q;
    end
  end

  // A live response into a full FIFO means memory ignored the credit limit.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_rvalid && (drop_q == '0) && (occ_q == Depth)));

endmodule
